// File: rtl/ddr3_uart_bridge_if.sv
// Wishbone request/response bundle between the UART bridge (master) and the
// DDR3 controller main slave port.
interface ddr3_uart_bridge_if #(
    parameter int WB_ADDR_BITS = 24,
    parameter int WB_DATA_BITS = 128,
    parameter int AUX_WIDTH    = 4
);
    logic                      o_wb_cyc;
    logic                      o_wb_stb;
    logic                      o_wb_we;
    logic [WB_ADDR_BITS-1:0]   o_wb_addr;
    logic [WB_DATA_BITS-1:0]   o_wb_data;
    logic [WB_DATA_BITS/8-1:0] o_wb_sel;
    logic [AUX_WIDTH-1:0]      o_aux;
    logic                      i_wb_stall;
    logic                      i_wb_ack;
    logic [WB_DATA_BITS-1:0]   i_wb_data;
    logic [AUX_WIDTH-1:0]      i_aux;

    modport master (
        output o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_data, o_wb_sel, o_aux,
        input  i_wb_stall, i_wb_ack, i_wb_data, i_aux
    );

    modport slave (
        input  o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_data, o_wb_sel, o_aux,
        output i_wb_stall, i_wb_ack, i_wb_data, i_aux
    );
endinterface

// File: rtl/ddr3_uart_bridge.sv
// UART byte -> pipelined Wishbone master for the DDR3 board demos, with a
// response FIFO paced out to the UART transmitter. Optional: BRIDGE_WRITE_ECHO_EN.
//
// state    | meaning
// WAIT_CAL | DDR3 not calibrated; everything held cleared, rx bytes dropped
// IDLE     | no request on the bus (stb low)
// REQ      | request registered on the bus (stb high), waiting for stall=0
module ddr3_uart_bridge #(
    parameter int WB_ADDR_BITS = 24,
    parameter int WB_DATA_BITS = 128,
    parameter int AUX_WIDTH    = 4,
    parameter int RESP_DEPTH   = 8
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_calib_done,
    input  logic                i_rx_valid,
    input  logic [7:0]          i_rx_data,
    ddr3_uart_bridge_if.master  wb,
    output logic                o_tx_en,
    output logic [7:0]          o_tx_data,
    input  logic                i_tx_busy,
    output logic                o_overflow,
    output logic                o_busy
);
    localparam int SEL_BITS = WB_DATA_BITS / 8;
    localparam int PTR_W    = $clog2(RESP_DEPTH);
    localparam int CNT_W    = PTR_W + 1;
    localparam int TOT_W    = 16;
    localparam int SUM_W    = TOT_W + 1;

    localparam logic [1:0] S_WAIT_CAL = 2'd0;
    localparam logic [1:0] S_IDLE     = 2'd1;
    localparam logic [1:0] S_REQ      = 2'd2;

    logic [1:0]              state;
    logic                    hold_valid;
    logic [7:0]              hold_byte;
    logic                    req_we;
    logic [WB_ADDR_BITS-1:0] req_addr;
    logic [WB_DATA_BITS-1:0] req_data;
    logic [SEL_BITS-1:0]     req_sel;
    logic [CNT_W-1:0]        out_rd;
    logic [TOT_W-1:0]        out_all;
    logic [7:0]              fifo_mem [RESP_DEPTH];
    logic [PTR_W-1:0]        wr_ptr;
    logic [PTR_W-1:0]        rd_ptr;
    logic [CNT_W-1:0]        fifo_cnt;
    logic                    tx_en_q;
    logic [7:0]              tx_data_q;
    logic                    overflow_q;

    logic             stb;
    logic             accept;
    logic             slot_free;
    logic             active;
    logic             is_wr;
    logic             is_rd;
    logic [7:0]       rd_alias;
    logic [7:0]       cmd_addr8;
    logic [SUM_W-1:0] credit_used;
    logic             credit_ok;
    logic             wr_ok;
    logic             load_req;
    logic             discard;
    logic             rd_inc;
    logic             rd_dec;
    logic             all_dec;
    logic             push;
    logic             push_ok;
    logic [7:0]       push_byte;
    logic             pop;
    logic [AUX_WIDTH-1:0] aux_out;
    logic             unused_ok;

    assign stb       = (state == S_REQ);
    assign accept    = stb & ~wb.i_wb_stall;
    assign slot_free = ~stb | accept;
    assign active    = (state != S_WAIT_CAL);

    assign is_wr     = (hold_byte >= 8'h61) && (hold_byte <= 8'h7A);
    assign is_rd     = (hold_byte >= 8'h41) && (hold_byte <= 8'h5A);
    assign rd_alias  = hold_byte + 8'd32;
    assign cmd_addr8 = is_wr ? ~hold_byte : ~rd_alias;

    // A request already on the bus counts against credit so a back-to-back
    // load can never promise more responses than the FIFO can hold.
`ifdef BRIDGE_WRITE_ECHO_EN
    assign credit_used = SUM_W'(out_all) + SUM_W'(fifo_cnt) + SUM_W'(stb);
    assign wr_ok       = credit_ok;
`else
    assign credit_used = SUM_W'(out_rd) + SUM_W'(fifo_cnt) + SUM_W'(stb & ~req_we);
    assign wr_ok       = 1'b1;
`endif
    assign credit_ok = credit_used < SUM_W'(RESP_DEPTH);

    assign load_req = active & hold_valid & slot_free & (is_wr ? wr_ok : (is_rd & credit_ok));
    assign discard  = active & hold_valid & ~is_wr & ~is_rd;

    assign rd_inc  = accept & ~req_we;
    assign rd_dec  = wb.i_wb_ack & ~wb.i_aux[0] & (out_rd != '0);
    assign all_dec = wb.i_wb_ack & (out_all != '0);

`ifdef BRIDGE_WRITE_ECHO_EN
    assign push = rd_dec | (all_dec & wb.i_aux[0]);
`else
    assign push = rd_dec;
`endif
    assign push_byte = rd_dec ? wb.i_wb_data[7:0] : 8'h21;
    assign push_ok   = push & (fifo_cnt != CNT_W'(RESP_DEPTH));
    assign pop       = (fifo_cnt != '0) & ~i_tx_busy & ~tx_en_q;

    always_comb begin
        aux_out    = '0;
        aux_out[0] = req_we;
    end

    assign unused_ok = ^{wb.i_wb_data, wb.i_aux};

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= S_WAIT_CAL;
            hold_valid <= 1'b0;
            hold_byte  <= '0;
            req_we     <= 1'b0;
            req_addr   <= '0;
            req_data   <= '0;
            req_sel    <= '0;
            out_rd     <= '0;
            out_all    <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_cnt   <= '0;
            tx_en_q    <= 1'b0;
            tx_data_q  <= '0;
            overflow_q <= 1'b0;
        end else if (!i_calib_done) begin
            // Calibration loss abandons everything in flight; late acks are ignored.
            state      <= S_WAIT_CAL;
            hold_valid <= 1'b0;
            out_rd     <= '0;
            out_all    <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_cnt   <= '0;
            tx_en_q    <= 1'b0;
            if (i_rx_valid) overflow_q <= 1'b1;
        end else begin
            case (state)
                S_WAIT_CAL: state <= S_IDLE;
                default: begin
                    if (load_req)    state <= S_REQ;
                    else if (accept) state <= S_IDLE;
                end
            endcase

            if (load_req || discard) hold_valid <= 1'b0;
            if (i_rx_valid) begin
                if (!active || hold_valid) begin
                    overflow_q <= 1'b1;
                end else begin
                    hold_valid <= 1'b1;
                    hold_byte  <= i_rx_data;
                end
            end

            if (load_req) begin
                req_we   <= is_wr;
                req_addr <= WB_ADDR_BITS'(cmd_addr8);
                req_data <= is_wr ? {SEL_BITS{hold_byte}} : '0;
                req_sel  <= '1;
            end

            case ({rd_inc, rd_dec})
                2'b10:   out_rd <= out_rd + CNT_W'(1);
                2'b01:   out_rd <= out_rd - CNT_W'(1);
                default: ;
            endcase

            case ({accept, all_dec})
                2'b10:   out_all <= out_all + TOT_W'(1);
                2'b01:   out_all <= out_all - TOT_W'(1);
                default: ;
            endcase

            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push_ok, pop})
                2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
                2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
                default: ;
            endcase

            tx_en_q <= pop;
            if (pop) tx_data_q <= fifo_mem[rd_ptr];
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst && i_calib_done && push_ok) fifo_mem[wr_ptr] <= push_byte;
    end

    assign wb.o_wb_stb  = stb;
    assign wb.o_wb_cyc  = stb | (out_all != '0);
    assign wb.o_wb_we   = req_we;
    assign wb.o_wb_addr = req_addr;
    assign wb.o_wb_data = req_data;
    assign wb.o_wb_sel  = req_sel;
    assign wb.o_aux     = aux_out;

    assign o_tx_en    = tx_en_q;
    assign o_tx_data  = tx_data_q;
    assign o_overflow = overflow_q;
    assign o_busy     = hold_valid | stb | (out_all != '0) | (fifo_cnt != '0);
endmodule

// File: doc/ddr3_uart_bridge.md
Name: ddr3_uart_bridge

Overview:
- Wishbone master that sits between the UART receiver/transmitter and the DDR3 controller's main Wishbone slave port in the board demos.
- Turns received ASCII bytes into pipelined Wishbone writes or reads, honouring stall and bounding outstanding reads.
- Buffers read responses in a small FIFO and paces them out to a busy-flagged UART transmitter.
- Replaces the ad-hoc, stall-unsafe glue in the demo tops.

Parameters:
- WB_ADDR_BITS, 24, width of o_wb_addr.
- WB_DATA_BITS, 128, width of Wishbone data buses; must be a multiple of 8.
- AUX_WIDTH, 4, width of aux lines; must be >= 1.
- RESP_DEPTH, 8, response FIFO depth; must be a power of 2 and >= 2.

Ports:
- i_clk  in  1  controller clock.
- i_rst  in  1  synchronous, active-high reset.
- i_calib_done  in  1  DDR3 calibration complete.
- i_rx_valid  in  1  one-cycle pulse, received byte valid.
- i_rx_data  in  8  received byte.
- o_wb_cyc  out  1  bus cycle.
- o_wb_stb  out  1  request strobe.
- o_wb_we  out  1  1 = write.
- o_wb_addr  out  WB_ADDR_BITS  request address.
- o_wb_data  out  WB_DATA_BITS  write data.
- o_wb_sel  out  WB_DATA_BITS/8  byte enables.
- o_aux  out  AUX_WIDTH  request tag.
- i_wb_stall  in  1  slave busy.
- i_wb_ack  in  1  request completed.
- i_wb_data  in  WB_DATA_BITS  read data.
- i_aux  in  AUX_WIDTH  returned tag.
- o_tx_en  out  1  one-cycle pulse, send o_tx_data.
- o_tx_data  out  8  byte to transmit.
- i_tx_busy  in  1  transmitter busy.
- o_overflow  out  1  sticky flag, an rx byte was dropped.
- o_busy  out  1  pending request, outstanding ack or non-empty FIFO.

Behaviour:
- Reset (i_rst=1 at a clock edge): all outputs 0; holding register, outstanding counter and FIFO cleared.
- States: WAIT_CAL, IDLE, REQ.
  - WAIT_CAL -> IDLE when i_calib_done=1.
  - Any state -> WAIT_CAL when i_calib_done=0; this clears the holding register, counter and FIFO and drops o_wb_cyc the same edge (cancels in-flight transactions). o_overflow is kept.
- Rx intake:
  - One-entry holding register, loaded on i_rx_valid in IDLE or REQ.
  - i_rx_valid while the register is full, or while in WAIT_CAL: byte dropped, o_overflow <= 1.
- Decode:
  - 0x61..0x7A (write): addr = zero-extend(~byte) to WB_ADDR_BITS; data = byte replicated across every byte lane.
  - 0x41..0x5A (read): addr = zero-extend(~(byte+8'd32)) with 8-bit wrap.
  - Any other byte: discarded in the cycle after loading, no bus activity.
  - o_wb_sel = all ones. o_aux = {0, we}.
- Issue:
  - Leaving the holding register, a request is registered into REQ: o_wb_stb and o_wb_cyc go high the cycle after the byte is loaded.
  - o_wb_stb and all request fields are held stable while i_wb_stall=1.
  - Request is accepted on an edge with stb=1 and stall=0; stb drops next cycle unless a new request is loaded that same edge (back-to-back issue permitted).
  - Read credit: a read is issued only if outstanding_reads + fifo_count < RESP_DEPTH; otherwise it waits in the holding register with stb=0.
- Outstanding counter:
  - +1 on an accepted read, -1 on an ack with i_aux[0]=0; both on one edge means no change.
  - Width clog2(RESP_DEPTH)+1. Ack with counter 0 is ignored; the counter never underflows.
- o_wb_cyc is high while stb=1 or any request (read or write) is outstanding; a separate total counter tracks this.
- Responses:
  - Read ack: i_wb_data[7:0] pushed into the FIFO on the ack edge.
  - FIFO never overflows thanks to the credit rule; a push when full is dropped regardless.
- Transmit:
  - o_tx_en=1 for one cycle when FIFO non-empty, i_tx_busy=0, and o_tx_en was 0 in the previous cycle.
  - Pops the FIFO at that edge; o_tx_data is valid in the same cycle.
- Latency: rx pulse at N -> stb at N+1 (no stall) -> ack at A -> o_tx_en at A+1 earliest.
- Simultaneous FIFO push and pop: count unchanged; push and pop use separate pointers with wrap at RESP_DEPTH.

Optional Feature:
- Macro: BRIDGE_WRITE_ECHO_EN.
- Defined: each write ack (i_aux[0]=1) pushes 0x21 ('!') into the response FIFO. Writes then also consume credit: credit check becomes outstanding_all + fifo_count < RESP_DEPTH.
- Undefined: write acks only decrement the total counter; nothing is transmitted.

Test Plan:
- Calibration gating: i_calib_done=0, rx 0x61 -> no stb, o_overflow=1; raise calib, rx 0x62 -> stb=1, we=1, addr=0x9D, data lanes all 0x62, o_aux=1.
- Stall hold: rx 0x41 with i_wb_stall=1 for 5 cycles -> stb/addr=0x9E/we=0 stable for 5 cycles, accepted on the 6th; ack with data[7:0]=0x61 -> o_tx_en pulse with o_tx_data=0x61.
- Credit limit, RESP_DEPTH=8: i_tx_busy=1, 9 reads, acks immediate -> exactly 8 accepted, 9th waits stb=0; one FIFO pop -> 9th issues.
- Drop/overflow: two rx pulses 1 cycle apart while stall=1 -> second byte dropped, o_overflow=1 sticky until i_rst. Rx 0x30 -> no bus activity.
- Calibration loss mid-operation: 3 reads outstanding, drop i_calib_done -> o_wb_cyc=0 next edge, o_busy=0, FIFO empty, no o_tx_en.
- Echo (BRIDGE_WRITE_ECHO_EN defined): rx 0x7A -> write addr=0x85; ack -> o_tx_en with 0x21.
